// File: rtl/router_sync_n.sv
// router_sync_n: routes packet writes to one of NUM_PORTS output FIFOs, returns the
// addressed FIFO's full flag, and issues a one-cycle soft reset to any port whose
// data sits unread for more than TIMEOUT cycles.
//
// Ports:
//   clk, resetn        clock and synchronous active-low reset
//   detect_add         latch data_in as the destination address on this edge
//   write_enb_reg      write request for the current packet byte
//   data_in            destination address
//   read_enb           per-port read enable from the destination
//   empty, full        per-port FIFO status flags
//   vld_out            per-port valid (~empty)
//   write_enb          one-hot write enable to the addressed FIFO
//   fifo_full          full flag of the addressed FIFO
//   addr_err           latched address has no matching port
//   soft_reset         per-port registered timeout pulse
//   sr_count           per-port saturating 8-bit soft-reset event counters,
//                      present only when ROUTER_SYNC_N_SRCNT_EN is defined
module router_sync_n #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 2,
    parameter int TIMEOUT   = 30
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   detect_add,
    input  logic                   write_enb_reg,
    input  logic [ADDR_W-1:0]      data_in,
    input  logic [NUM_PORTS-1:0]   read_enb,
    input  logic [NUM_PORTS-1:0]   empty,
    input  logic [NUM_PORTS-1:0]   full,
    output logic [NUM_PORTS-1:0]   vld_out,
    output logic [NUM_PORTS-1:0]   write_enb,
    output logic                   fifo_full,
    output logic                   addr_err,
`ifdef ROUTER_SYNC_N_SRCNT_EN
    output logic [NUM_PORTS-1:0]   soft_reset,
    output logic [8*NUM_PORTS-1:0] sr_count
`else
    output logic [NUM_PORTS-1:0]   soft_reset
`endif
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [ADDR_W-1:0]    addr_q;
    logic [CNT_W-1:0]     cnt [NUM_PORTS];
    logic [NUM_PORTS-1:0] stall;
    logic [NUM_PORTS-1:0] hit;

    assign vld_out  = ~empty;
    assign stall    = vld_out & ~read_enb;
    // One extra bit so NUM_PORTS == 2**ADDR_W compares correctly.
    assign addr_err = {1'b0, addr_q} >= (ADDR_W + 1)'(NUM_PORTS);

    // Decoding by equality with each valid port index means an out-of-range
    // address naturally selects nothing.
    always_comb begin
        write_enb = '0;
        fifo_full = 1'b0;
        hit       = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            write_enb[i] = write_enb_reg && addr_q == ADDR_W'(i);
            fifo_full    = fifo_full | (full[i] && addr_q == ADDR_W'(i));
            hit[i]       = stall[i] && cnt[i] == CNT_W'(TIMEOUT);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr_q     <= '0;
            soft_reset <= '0;
            for (int i = 0; i < NUM_PORTS; i++) cnt[i] <= '0;
        end else begin
            if (detect_add) addr_q <= data_in;
            soft_reset <= hit;
            for (int i = 0; i < NUM_PORTS; i++)
                cnt[i] <= (stall[i] && !hit[i]) ? cnt[i] + 1'b1 : '0;
        end
    end

`ifdef ROUTER_SYNC_N_SRCNT_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sr_count <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++)
                if (hit[i] && sr_count[8*i +: 8] != 8'hff)
                    sr_count[8*i +: 8] <= sr_count[8*i +: 8] + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_router_sync_n.sv
// tb_router_sync_n: directed bench for router_sync_n (default 3-port instance plus a
// 5-port, TIMEOUT=4 instance).
module tb_router_sync_n;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn, de, wer;
    logic [1:0] din;
    logic [2:0] re, em, fu, vld, we, sr;
    logic       ff, ae;

    logic       b_resetn, b_de, b_wer;
    logic [2:0] b_din;
    logic [4:0] b_re, b_em, b_fu, b_vld, b_we, b_sr;
    logic       b_ff, b_ae;

`ifdef ROUTER_SYNC_N_SRCNT_EN
    logic [23:0] src;
    logic [39:0] b_src;
`endif

    router_sync_n dut (
        .clk(clk), .resetn(resetn), .detect_add(de), .write_enb_reg(wer),
        .data_in(din), .read_enb(re), .empty(em), .full(fu),
        .vld_out(vld), .write_enb(we), .fifo_full(ff), .addr_err(ae),
`ifdef ROUTER_SYNC_N_SRCNT_EN
        .sr_count(src),
`endif
        .soft_reset(sr)
    );

    router_sync_n #(.NUM_PORTS(5), .ADDR_W(3), .TIMEOUT(4)) dut_b (
        .clk(clk), .resetn(b_resetn), .detect_add(b_de), .write_enb_reg(b_wer),
        .data_in(b_din), .read_enb(b_re), .empty(b_em), .full(b_fu),
        .vld_out(b_vld), .write_enb(b_we), .fifo_full(b_ff), .addr_err(b_ae),
`ifdef ROUTER_SYNC_N_SRCNT_EN
        .sr_count(b_src),
`endif
        .soft_reset(b_sr)
    );

    typedef struct {
        logic       de, wer;
        logic [1:0] din;
        logic [2:0] em, fu;
        logic [2:0] x_we;
        logic       x_ff, x_ae;
        logic [2:0] x_vld;
    } vec_t;

    vec_t tab [12];
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic reset_a();
        resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic reset_b();
        b_resetn = 1'b0;
        @(posedge clk);
        #1 b_resetn = 1'b1;
    endtask

    initial begin
        // de wer din em fu | we ff ae vld ; read_enb held high so nothing stalls
        tab[0]  = '{1'b0, 1'b1, 2'd0, 3'b111, 3'b000, 3'b001, 1'b0, 1'b0, 3'b000};
        tab[1]  = '{1'b1, 1'b1, 2'd2, 3'b111, 3'b001, 3'b001, 1'b1, 1'b0, 3'b000};
        tab[2]  = '{1'b0, 1'b1, 2'd0, 3'b111, 3'b000, 3'b100, 1'b0, 1'b0, 3'b000};
        tab[3]  = '{1'b0, 1'b1, 2'd0, 3'b111, 3'b100, 3'b100, 1'b1, 1'b0, 3'b000};
        tab[4]  = '{1'b0, 1'b0, 2'd0, 3'b111, 3'b001, 3'b000, 1'b0, 1'b0, 3'b000};
        tab[5]  = '{1'b0, 1'b0, 2'd0, 3'b010, 3'b000, 3'b000, 1'b0, 1'b0, 3'b101};
        tab[6]  = '{1'b1, 1'b1, 2'd3, 3'b111, 3'b111, 3'b100, 1'b1, 1'b0, 3'b000};
        tab[7]  = '{1'b0, 1'b1, 2'd0, 3'b111, 3'b111, 3'b000, 1'b0, 1'b1, 3'b000};
        tab[8]  = '{1'b1, 1'b0, 2'd1, 3'b111, 3'b111, 3'b000, 1'b0, 1'b1, 3'b000};
        tab[9]  = '{1'b0, 1'b1, 2'd0, 3'b111, 3'b010, 3'b010, 1'b1, 1'b0, 3'b000};
        tab[10] = '{1'b0, 1'b1, 2'd0, 3'b111, 3'b101, 3'b010, 1'b0, 1'b0, 3'b000};
        tab[11] = '{1'b1, 1'b1, 2'd0, 3'b000, 3'b000, 3'b010, 1'b0, 1'b0, 3'b111};

        de = 0; wer = 0; din = 0; re = 3'b111; em = 3'b111; fu = 3'b001;
        b_de = 0; b_wer = 0; b_din = 0; b_re = 0; b_em = 5'b11111; b_fu = 0;
        b_resetn = 1'b0;
        reset_a();
        chk("reset_we", we, 3'b000);
        chk("reset_ae", ae, 1'b0);
        chk("reset_ff", ff, 1'b1);
        chk("reset_sr", sr, 3'b000);

        for (int i = 0; i < 12; i++) begin
            de = tab[i].de; wer = tab[i].wer; din = tab[i].din;
            em = tab[i].em; fu = tab[i].fu; re = 3'b111;
            @(negedge clk);
            chk($sformatf("v%0d_we", i), we, tab[i].x_we);
            chk($sformatf("v%0d_ff", i), ff, tab[i].x_ff);
            chk($sformatf("v%0d_ae", i), ae, tab[i].x_ae);
            chk($sformatf("v%0d_vld", i), vld, tab[i].x_vld);
            chk($sformatf("v%0d_sr", i), sr, 3'b000);
            @(posedge clk);
            #1;
        end
        de = 0; wer = 0;

        // Port 1 stalled continuously: pulses after edges 31 and 62 only.
        em = 3'b111; re = 3'b000;
        reset_a();
        em = 3'b101;
        for (int k = 1; k <= 62; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("to_e%0d", k), sr, (k == 31 || k == 62) ? 3'b010 : 3'b000);
        end

        // Port 0: 30 stalled edges, one read on the would-be threshold edge, then 31 more.
        em = 3'b111;
        reset_a();
        em = 3'b110;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("int_a%0d", k), sr, 3'b000);
        end
        re = 3'b001;
        @(posedge clk);
        @(negedge clk);
        chk("int_read_edge", sr, 3'b000);
        re = 3'b000;
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("int_b%0d", k), sr, (k == 31) ? 3'b001 : 3'b000);
        end

        // 5-port instance: all ports stalled from reset.
        reset_b();
        b_em = 5'b00000;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("b_all_e%0d", k), b_sr, (k == 5) ? 5'b11111 : 5'b00000);
        end
        reset_b();
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("b_pre_e%0d", k), b_sr, 5'b00000);
        end
        b_resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("b_mid_reset", b_sr, 5'b00000);
        b_resetn = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("b_post_e%0d", k), b_sr, (k == 5) ? 5'b11111 : 5'b00000);
        end
        b_din = 3'd4; b_de = 1'b1;
        @(posedge clk);
        #1 b_de = 1'b0; b_wer = 1'b1; b_fu = 5'b10000;
        @(negedge clk);
        chk("b_we4", b_we, 5'b10000);
        chk("b_ff4", b_ff, 1'b1);
        chk("b_ae4", b_ae, 1'b0);
        b_din = 3'd5; b_de = 1'b1;
        @(posedge clk);
        #1 b_de = 1'b0; b_fu = 5'b11111;
        @(negedge clk);
        chk("b_we5", b_we, 5'b00000);
        chk("b_ff5", b_ff, 1'b0);
        chk("b_ae5", b_ae, 1'b1);

`ifdef ROUTER_SYNC_N_SRCNT_EN
        em = 3'b111; re = 3'b000;
        reset_a();
        chk("src_reset", src, 24'h000000);
        em = 3'b101;
        repeat (62) @(posedge clk);
        @(negedge clk);
        chk("src_two", src, 24'h000200);
        repeat (298 * 31) @(posedge clk);
        @(negedge clk);
        chk("src_sat", src, 24'h00ff00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
